fb_ring_ctrl: RTL and testbench

Parametrised successor to the ping-pong capture controller. It sequences system init, then manages a ring of NUM_FB framebuffers in triple-buffer fashion: the camera writer never writes the buffer being displayed, and the display reader always takes the newest completed frame. It arbitrates the shared memory port between write and read bursts of BURST_LEN beats. Arbitration is work-conserving, and skipped and repeated frames are counted.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_burst_arb.sv | 54 +++++
 rtl/fb_ring_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fb_ring_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and helpers for the framebuffer ring controller family
// Contents: control FSM states, arbiter phase encoding, modulo-N increment.
package fb_pkg;

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_INIT      = 2'd1,
        S_INIT_WAIT = 2'd2,
        S_STREAM    = 2'd3
    } fsm_state_t;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } phase_t;

    // Increment that wraps at n rather than at a power of two.
    function automatic logic [31:0] mod_inc(input logic [31:0] v, input int unsigned n);
        return (v >= n - 1) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/fb_burst_arb.sv
// rtl/fb_burst_arb.sv - work-conserving write/read burst arbiter for one shared memory port
// Ports: clk, reset (sync, active-high); wreq/rreq request terms; avl_ready beat
// acceptance; phase = side that currently owns the port.
module fb_burst_arb
    import fb_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   wreq,
    input  logic   rreq,
    input  logic   avl_ready,
    output phase_t phase
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    phase_t          phase_q, phase_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            cur_req, oth_req;

    always_comb begin
        cur_req    = (phase_q == WR) ? wreq : rreq;
        oth_req    = (phase_q == WR) ? rreq : wreq;
        phase_d    = phase_q;
        beat_cnt_d = beat_cnt_q;
        if (cur_req && avl_ready) begin
            if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
                phase_d    = (phase_q == WR) ? RD : WR;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end else if (!cur_req && oth_req) begin
            // Idle owner hands the port over at once instead of burning a burst slot.
            phase_d    = (phase_q == WR) ? RD : WR;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= WR;
            beat_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/fb_ring_ctrl.sv
// rtl/fb_ring_ctrl.sv - init sequencer plus NUM_FB-deep framebuffer ring with burst arbitration
// Ports: clk, reset (sync, active-high); init_done/init_start handshake; wr/rd_frame_done
// frame pulses; memory and FIFO status inputs; memory/FIFO enables; ring indices,
// rd_valid, streaming; saturating skip_cnt and repeat_cnt.
module fb_ring_ctrl
    import fb_pkg::*;
#(
    parameter int NUM_FB          = 3,
    parameter int FB_W            = 4,
    parameter int BURST_LEN       = 8,
    parameter int READS_PER_FRAME = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_done,
    output logic             init_start,
    input  logic             wr_frame_done,
    input  logic             rd_frame_done,
    input  logic             avl_ready,
    input  logic             cam_rdempty,
    input  logic             adv_wrfull,
    input  logic             adv_rdempty,
    input  logic             hdmi_de,
    input  logic             rd_data_valid,
    output logic             wr_en,
    output logic             rd_en,
    output logic             rdreq_cam,
    output logic             wrreq_adv,
    output logic             rdreq_adv,
    output logic [FB_W-1:0]  wr_fb_idx,
    output logic [FB_W-1:0]  rd_fb_idx,
    output logic             rd_valid,
    output logic             streaming,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] repeat_cnt
);

    if (NUM_FB < 3 || NUM_FB > 16) begin : g_bad_num_fb
        $error("fb_ring_ctrl: NUM_FB must be in 3..16");
    end
    if ((2 ** FB_W) < NUM_FB) begin : g_bad_fb_w
        $error("fb_ring_ctrl: FB_W too narrow for NUM_FB");
    end

    localparam int PASS_W = 4;

    function automatic logic [FB_W-1:0] fb_inc(input logic [FB_W-1:0] v);
        return FB_W'(mod_inc(32'(v), NUM_FB));
    endfunction

    // Control FSM
    fsm_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_INIT;
            S_INIT:      state_d = S_INIT_WAIT;
            S_INIT_WAIT: if (init_done) state_d = S_STREAM;
            S_STREAM:    state_d = S_STREAM;
            default:     state_d = S_RESET;
        endcase
    end

    assign streaming  = (state_q == S_STREAM);
    assign init_start = (state_q == S_INIT);

    // Arbitration and enables
    logic   wreq, rreq;
    phase_t phase;

    assign wreq = streaming & ~cam_rdempty;
    assign rreq = streaming & rd_valid & ~adv_wrfull & hdmi_de;

    fb_burst_arb #(.BURST_LEN(BURST_LEN)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .wreq      (wreq),
        .rreq      (rreq),
        .avl_ready (avl_ready),
        .phase     (phase)
    );

    assign wr_en     = wreq & (phase == WR);
    assign rd_en     = rreq & (phase == RD);
    assign rdreq_cam = wr_en & avl_ready;
    assign wrreq_adv = streaming & rd_data_valid;
    assign rdreq_adv = streaming & hdmi_de & ~adv_rdempty;

    // Buffer ring
    logic [FB_W-1:0]   wr_fb_idx_q, wr_fb_idx_d, rd_fb_idx_q, rd_fb_idx_d;
    logic [FB_W-1:0]   last_done_q, last_done_d, wr_step;
    logic              rd_valid_q, rd_valid_d, last_valid_q, last_valid_d;
    logic              last_taken_q, last_taken_d, take, wr_done, rd_done;
    logic [PASS_W-1:0] rd_pass_q, rd_pass_d;
    logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d, repeat_cnt_q, repeat_cnt_d;

    always_comb begin
        wr_done      = streaming & wr_frame_done;
        rd_done      = streaming & rd_frame_done;
        take         = 1'b0;
        rd_valid_d   = rd_valid_q;
        rd_pass_d    = rd_pass_q;
        repeat_cnt_d = repeat_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        last_done_d  = last_done_q;
        last_valid_d = last_valid_q;
        last_taken_d = last_taken_q;
        wr_fb_idx_d  = wr_fb_idx_q;
        wr_step      = fb_inc(wr_fb_idx_q);

        // Reader first: its choice (rd_fb_idx_d) is what the writer must avoid.
        if (!rd_valid_q && last_valid_q) begin
            take       = 1'b1;
            rd_valid_d = 1'b1;
        end else if (rd_done && rd_valid_q) begin
            if (rd_pass_q == PASS_W'(READS_PER_FRAME - 1)) begin
                rd_pass_d = '0;
                if (!last_taken_q) begin
                    take = 1'b1;
                end else if (repeat_cnt_q != '1) begin
                    repeat_cnt_d = repeat_cnt_q + 1'b1;
                end
            end else begin
                rd_pass_d = rd_pass_q + 1'b1;
            end
        end
        rd_fb_idx_d = take ? last_done_q : rd_fb_idx_q;
        if (take) begin
            last_taken_d = 1'b1;
        end

        // Writer: the just-finished buffer becomes the fresh candidate even if the
        // reader grabbed the previous candidate in this same cycle.
        if (wr_done) begin
            if (last_valid_q && !last_taken_q && !take && skip_cnt_q != '1) begin
                skip_cnt_d = skip_cnt_q + 1'b1;
            end
            last_done_d  = wr_fb_idx_q;
            last_valid_d = 1'b1;
            last_taken_d = 1'b0;
            wr_fb_idx_d  = (rd_valid_d && wr_step == rd_fb_idx_d) ? fb_inc(wr_step) : wr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            wr_fb_idx_q  <= '0;
            rd_fb_idx_q  <= '0;
            rd_valid_q   <= 1'b0;
            last_done_q  <= '0;
            last_valid_q <= 1'b0;
            last_taken_q <= 1'b0;
            rd_pass_q    <= '0;
            skip_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_fb_idx_q  <= wr_fb_idx_d;
            rd_fb_idx_q  <= rd_fb_idx_d;
            rd_valid_q   <= rd_valid_d;
            last_done_q  <= last_done_d;
            last_valid_q <= last_valid_d;
            last_taken_q <= last_taken_d;
            rd_pass_q    <= rd_pass_d;
            skip_cnt_q   <= skip_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign wr_fb_idx  = wr_fb_idx_q;
    assign rd_fb_idx  = rd_fb_idx_q;
    assign rd_valid   = rd_valid_q;
    assign skip_cnt   = skip_cnt_q;
    assign repeat_cnt = repeat_cnt_q;

endmodule

// File: tb/tb_fb_ring_ctrl.sv
// tb/tb_fb_ring_ctrl.sv - directed scoreboard bench for fb_ring_ctrl (NUM_FB=3, BURST_LEN=8)
module tb_fb_ring_ctrl;

    logic        clk = 1'b0;
    logic        reset, init_done, init_start, wr_frame_done, rd_frame_done;
    logic        avl_ready, cam_rdempty, adv_wrfull, adv_rdempty, hdmi_de, rd_data_valid;
    logic        wr_en, rd_en, rdreq_cam, wrreq_adv, rdreq_adv, rd_valid, streaming;
    logic [3:0]  wr_fb_idx, rd_fb_idx;
    logic [15:0] skip_cnt, repeat_cnt;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    fb_ring_ctrl #(
        .NUM_FB(3), .FB_W(4), .BURST_LEN(8), .READS_PER_FRAME(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .init_start(init_start),
        .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
        .avl_ready(avl_ready), .cam_rdempty(cam_rdempty), .adv_wrfull(adv_wrfull),
        .adv_rdempty(adv_rdempty), .hdmi_de(hdmi_de), .rd_data_valid(rd_data_valid),
        .wr_en(wr_en), .rd_en(rd_en), .rdreq_cam(rdreq_cam), .wrreq_adv(wrreq_adv),
        .rdreq_adv(rdreq_adv), .wr_fb_idx(wr_fb_idx), .rd_fb_idx(rd_fb_idx),
        .rd_valid(rd_valid), .streaming(streaming), .skip_cnt(skip_cnt),
        .repeat_cnt(repeat_cnt)
    );

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_underflow: observed %0h required none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h required %0h", t, obs, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic w, input logic r);
        wr_frame_done = w;
        rd_frame_done = r;
        cyc();
        wr_frame_done = 1'b0;
        rd_frame_done = 1'b0;
    endtask

    initial begin
        int ip, en_seen, st_seen, wcyc, wbeats;
        logic done;
        reset = 1'b1; init_done = 1'b0; wr_frame_done = 1'b0; rd_frame_done = 1'b0;
        avl_ready = 1'b0; cam_rdempty = 1'b1; adv_wrfull = 1'b0; adv_rdempty = 1'b1;
        hdmi_de = 1'b0; rd_data_valid = 1'b0;
        cyc(); cyc();

        // Reset state
        push("reset_flags", 32'd0);
        #1 check({24'd0, init_start, streaming, wr_en, rd_en, rdreq_cam, wrreq_adv, rdreq_adv, rd_valid});
        push("reset_idx", 32'd0);
        check({24'd0, wr_fb_idx, rd_fb_idx});
        push("reset_cnt", 32'd0);
        check({skip_cnt, repeat_cnt});

        // Init sequence: everything gated off, frame pulses ignored
        reset = 1'b0;
        cam_rdempty = 1'b0; rd_data_valid = 1'b1; hdmi_de = 1'b1; adv_rdempty = 1'b0;
        avl_ready = 1'b1; wr_frame_done = 1'b1; rd_frame_done = 1'b1;
        ip = 0; en_seen = 0; st_seen = 0;
        push("init_pulses", 32'd1);
        push("init_enables", 32'd0);
        push("init_streaming", 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            ip += int'(init_start);
            if (wr_en | rd_en | rdreq_cam | wrreq_adv | rdreq_adv) en_seen++;
            if (streaming) st_seen++;
        end
        check(ip);
        check(en_seen);
        check(st_seen);
        wr_frame_done = 1'b0; rd_frame_done = 1'b0;
        cam_rdempty = 1'b1; rd_data_valid = 1'b0; hdmi_de = 1'b0; adv_rdempty = 1'b1;
        init_done = 1'b1;
        push("pre_stream", 32'd0);
        #1 check(streaming);
        cyc(); cyc();
        push("streaming", 32'd1);
        #1 check(streaming);
        push("ignored_frames", 32'd0);
        check({27'd0, wr_fb_idx, rd_valid});

        // First frame: reader takes buffer 0, writer moves to 1
        pulse(1'b1, 1'b0);
        cyc();
        push("first_take", {16'd0, 4'd1, 4'd0, 8'd1});
        #1 check({16'd0, wr_fb_idx, rd_fb_idx, 7'd0, rd_valid});
        // Two passes with nothing newer -> repeat
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        push("repeat", {16'd1, 4'd0, 12'd0});
        #1 check({repeat_cnt, rd_fb_idx, 12'd0});
        pulse(1'b1, 1'b0);
        push("wr_wrap_step", 32'd2);
        #1 check(wr_fb_idx);
        // Consume frame 1
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        push("switch_rd", {4'd1, 12'd0, 16'd1});
        #1 check({rd_fb_idx, 12'd0, repeat_cnt});

        // Overrun: writer laps, never landing on the displayed buffer (rd=1)
        pulse(1'b1, 1'b0);
        push("lap1", {4'd0, 4'd1, 8'd0, 16'd0});
        #1 check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt});
        pulse(1'b1, 1'b0);
        push("lap2", {4'd2, 4'd1, 8'd0, 16'd1});
        #1 check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt});
        pulse(1'b1, 1'b0);
        push("lap3", {4'd0, 4'd1, 8'd0, 16'd2});
        #1 check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt});
        pulse(1'b1, 1'b0);
        push("lap4", {4'd2, 4'd1, 8'd0, 16'd3});
        #1 check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt});

        // Simultaneous final read pass and write done: reader takes 0, writer skips 0 -> 1
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        push("simul", {4'd1, 4'd0, 8'd0, 16'd3});
        #1 check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt});
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        push("simul_next", {4'd2, 12'd0, 16'd1});
        #1 check({rd_fb_idx, 12'd0, repeat_cnt});

        // Alternating 8-beat bursts with both sides requesting
        cam_rdempty = 1'b0; hdmi_de = 1'b1; adv_wrfull = 1'b0; avl_ready = 1'b1;
        rd_data_valid = 1'b1; adv_rdempty = 1'b0;
        push("adv_reqs", 32'd3);
        #1 check({30'd0, wrreq_adv, rdreq_adv});
        for (int i = 0; i < 32; i++) begin
            push("burst_en", ((i / 8) % 2 == 0) ? 32'b101 : 32'b010);
            check({29'd0, wr_en, rd_en, rdreq_cam});
            cyc();
            #1;
        end

        // Stalled write burst: 3 dead cycles stretch it to 11 cycles, still 8 beats
        wcyc = 0; wbeats = 0; done = 1'b0;
        for (int j = 0; j < 30 && !done; j++) begin
            avl_ready = (j < 3 || j >= 6);
            #1;
            if (rd_en) begin
                done = 1'b1;
            end else begin
                if (wr_en) wcyc++;
                if (wr_en && avl_ready) wbeats++;
            end
            cyc();
        end
        push("stall_done", 32'd1);
        check({31'd0, done});
        push("stall_cycles", 32'd11);
        check(wcyc);
        push("stall_beats", 32'd8);
        check(wbeats);

        // Work-conserving handover both ways
        avl_ready = 1'b1;
        hdmi_de = 1'b0;
        push("rd_idle", 32'b00);
        #1 check({30'd0, wr_en, rd_en});
        cyc();
        push("to_wr", 32'b10);
        #1 check({30'd0, wr_en, rd_en});
        cam_rdempty = 1'b1; hdmi_de = 1'b1;
        push("wr_idle", 32'b00);
        #1 check({30'd0, wr_en, rd_en});
        cyc();
        push("to_rd", 32'b01);
        #1 check({30'd0, wr_en, rd_en});

        // Reset in mid-burst
        reset = 1'b1;
        cyc();
        push("midburst_flags", 32'd0);
        #1 check({24'd0, init_start, streaming, wr_en, rd_en, rdreq_cam, wrreq_adv, rdreq_adv, rd_valid});
        push("midburst_idx_cnt", 32'd0);
        check({wr_fb_idx, rd_fb_idx, 8'd0, skip_cnt | repeat_cnt});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
